// File: rtl/laser_pkg.sv
// Shared constants, FSM states, point type and squared-distance helper for the laser host.
package laser_pkg;

   localparam int N_PTS = 40;
   localparam int R2    = 16;
   localparam int CW    = 4;
   localparam int IW    = 6;

   typedef enum logic [2:0] {IDLE, ERST, STREAM, WAIT, SCORE, REPORT} state_t;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } point_t;

   // Full-precision squared distance: 5-bit signed deltas, 8-bit squares, 9-bit sum.
   function automatic logic [8:0] dist2(input point_t a, input point_t b);
      logic [4:0] dx, dy;
      logic [3:0] ax, ay;
      logic [7:0] sx, sy;
      dx = {1'b0, a.x} - {1'b0, b.x};
      dy = {1'b0, a.y} - {1'b0, b.y};
      ax = dx[4] ? 4'(-dx) : dx[3:0];
      ay = dy[4] ? 4'(-dy) : dy[3:0];
      sx = 8'(ax) * 8'(ax);
      sy = 8'(ay) * 8'(ay);
      return {1'b0, sx} + {1'b0, sy};
   endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage test: hit when the point lies within radius 4 of either centre.
// Zero latency; no flow control.
module laser_cover_chk
   import laser_pkg::*;
(
   input  logic [7:0] pt_i,
   input  logic [7:0] c1_i,
   input  logic [7:0] c2_i,
   output logic       hit_o
);

   point_t pt, c1, c2;

   assign pt = pt_i;
   assign c1 = c1_i;
   assign c2 = c2_i;

   assign hit_o = (dist2(pt, c1) <= 9'(R2)) || (dist2(pt, c2) <= 9'(R2));

endmodule

// File: rtl/laser_host.sv
// Host driver for the laser engine: holds the point set, resets and feeds the engine, captures and scores centres.
// One run = RST_CYC + N_PTS+1 + wait + N_PTS cycles; START and LD_EN are ignored while BUSY.
module laser_host
   import laser_pkg::*;
#(
   parameter int RST_CYC = 2,
   parameter int WD_W    = 20
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       LD_EN,
   input  logic [5:0] LD_ADDR,
   input  logic [3:0] LD_X,
   input  logic [3:0] LD_Y,
   input  logic       START,
   output logic       ENG_RST,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       DONE,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   output logic       BUSY,
   output logic       RES_VALID,
   output logic [5:0] HIT_CNT,
   output logic [3:0] RC1X,
   output logic [3:0] RC1Y,
   output logic [3:0] RC2X,
   output logic [3:0] RC2Y,
   output logic       TIMEOUT
);

   localparam logic [IW-1:0]   END_S    = IW'(N_PTS);
   localparam logic [IW-1:0]   LAST_IDX = IW'(N_PTS - 1);
   localparam logic [IW-1:0]   RST_LAST = IW'(RST_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONES  = '1;

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            eng_rst_q, eng_rst_d;
   logic            to_q, to_d;
   logic [IW-1:0]   hit_q, hit_d;
   point_t          xy_q, xy_d;
   point_t          rc1_q, rc1_d;
   point_t          rc2_q, rc2_d;

   point_t          mem [N_PTS];
   point_t          rd_pt;
   logic            busy;
   logic            hit;

   assign busy  = state_q inside {ERST, STREAM, WAIT, SCORE};
   assign rd_pt = mem[(cnt_q < END_S) ? cnt_q : '0];

   // Point buffer deliberately has no reset so a mid-run abort keeps the loaded frame.
   always_ff @(posedge CLK) begin
      if (LD_EN && !busy && (LD_ADDR < END_S)) begin
         mem[LD_ADDR] <= {LD_X, LD_Y};
      end
   end

   laser_cover_chk u_cover (
      .pt_i  (rd_pt),
      .c1_i  (rc1_q),
      .c2_i  (rc2_q),
      .hit_o (hit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      to_d    = to_q;
      hit_d   = hit_q;
      xy_d    = xy_q;
      rc1_d   = rc1_q;
      rc2_d   = rc2_q;
      case (state_q)
         IDLE, REPORT: begin
            if (START) begin
               state_d = ERST;
               cnt_d   = '0;
               to_d    = 1'b0;
               hit_d   = '0;
            end
         end
         ERST: begin
            if (cnt_q == RST_LAST) begin
               state_d = STREAM;
               cnt_d   = '0;
               xy_d    = mem[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STREAM: begin
            // Output lags the index by one so point k is stable during stream cycle k+1.
            if (cnt_q == END_S) begin
               state_d = WAIT;
               wd_d    = '0;
            end else begin
               xy_d  = rd_pt;
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT: begin
            if (DONE) begin
               state_d = SCORE;
               cnt_d   = '0;
               rc1_d   = {C1X, C1Y};
               rc2_d   = {C2X, C2Y};
            end else if ((wd_q + 1'b1) == WD_ONES) begin
               state_d = REPORT;
               to_d    = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         SCORE: begin
            hit_d = hit_q + IW'(hit);
            if (cnt_q == LAST_IDX) begin
               state_d = REPORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      eng_rst_d = !(state_d inside {STREAM, WAIT, SCORE});
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wd_q      <= '0;
         eng_rst_q <= 1'b1;
         to_q      <= 1'b0;
         hit_q     <= '0;
         xy_q      <= '0;
         rc1_q     <= '0;
         rc2_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wd_q      <= wd_d;
         eng_rst_q <= eng_rst_d;
         to_q      <= to_d;
         hit_q     <= hit_d;
         xy_q      <= xy_d;
         rc1_q     <= rc1_d;
         rc2_q     <= rc2_d;
      end
   end

   assign ENG_RST   = eng_rst_q;
   assign X         = xy_q.x;
   assign Y         = xy_q.y;
   assign BUSY      = busy;
   assign RES_VALID = (state_q == REPORT);
   assign HIT_CNT   = hit_q;
   assign RC1X      = rc1_q.x;
   assign RC1Y      = rc1_q.y;
   assign RC2X      = rc2_q.x;
   assign RC2Y      = rc2_q.y;
   assign TIMEOUT   = to_q;

endmodule
